// File: rtl/hazard_issue_ctrl.sv
// Issue controller between IF_ID and ID_EX: per-register writeback countdown scoreboard for
// RAW stalls, plus jump serialisation (hold until EX resolves, then flush wrong-path fetches).
module hazard_issue_ctrl #(
   parameter int WB_LATENCY   = 3,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        id_valid,
   input  logic [4:0]  id_rs1_addr,
   input  logic        id_rs1_rd_en,
   input  logic [4:0]  id_rs2_addr,
   input  logic        id_rs2_rd_en,
   input  logic [4:0]  id_rd_addr,
   input  logic        id_rd_wr_en,
   input  logic        id_is_jump,
   input  logic        ex_jump_done,
   output logic        issue,
   output logic        stall,
   output logic        flush,
   output logic [31:0] busy_mask
);

   // state  | meaning
   // RUN    | normal issue, RAW hazards stall ID
   // JWAIT  | jump issued, issue held until EX redirects the PC
   // FLUSH  | wrong-path fetches marked do_not_execute, fetch proceeds

   localparam int CW = (WB_LATENCY   > 1) ? $clog2(WB_LATENCY + 1)   : 1;
   localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_JWAIT = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t        state;
   logic [FW-1:0] flush_cnt;
   logic [CW-1:0] cnt [1:31];

   logic [31:0]   busy_r;
   logic [31:0]   pend;
   logic          hz;
   logic          issue_c;
   logic          stall_c;
   logic          flush_c;

   // A reader may issue in the writeback cycle itself (cnt == 1), so only
   // counts above one block a dependent instruction.
   always_comb begin
      busy_r = '0;
      pend   = '0;
      for (int r = 1; r < 32; r++) begin
         busy_r[r] = (cnt[r] != '0);
         pend[r]   = (cnt[r] > CW'(1));
      end
   end

   assign hz = (id_rs1_rd_en & pend[id_rs1_addr]) |
               (id_rs2_rd_en & pend[id_rs2_addr]);

   always_comb begin
      issue_c = 1'b0;
      stall_c = 1'b0;
      flush_c = 1'b0;
      if (!reset) begin
         case (state)
            ST_RUN: begin
               issue_c = id_valid & ~hz;
               stall_c = id_valid & hz;
            end
            ST_JWAIT: begin
               stall_c = id_valid;
               flush_c = ex_jump_done;
            end
            ST_FLUSH: begin
               flush_c = 1'b1;
            end
            default: begin
               issue_c = 1'b0;
            end
         endcase
      end
   end

   assign issue     = issue_c;
   assign stall     = stall_c;
   assign flush     = flush_c;
   assign busy_mask = reset ? '0 : busy_r;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_RUN;
         flush_cnt <= '0;
         for (int r = 1; r < 32; r++) begin
            cnt[r] <= '0;
         end
      end else begin
         for (int r = 1; r < 32; r++) begin
            if (issue_c && id_rd_wr_en && (id_rd_addr == 5'(r))) begin
               cnt[r] <= CW'(WB_LATENCY);
            end else if (cnt[r] != '0) begin
               cnt[r] <= cnt[r] - CW'(1);
            end
         end

         // flush_cnt holds the flush cycles still owed after the current one;
         // the resolving cycle in JWAIT is the first flush cycle.
         case (state)
            ST_RUN: begin
               if (issue_c && id_is_jump) begin
                  state <= ST_JWAIT;
               end
            end
            ST_JWAIT: begin
               if (ex_jump_done) begin
                  if (FLUSH_CYCLES > 1) begin
                     state     <= ST_FLUSH;
                     flush_cnt <= FW'(FLUSH_CYCLES - 1);
                  end else begin
                     state <= ST_RUN;
                  end
               end
            end
            ST_FLUSH: begin
               if (flush_cnt <= FW'(1)) begin
                  state     <= ST_RUN;
                  flush_cnt <= '0;
               end else begin
                  flush_cnt <= flush_cnt - FW'(1);
               end
            end
            default: begin
               state     <= ST_RUN;
               flush_cnt <= '0;
            end
         endcase
      end
   end

endmodule
